// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending-machine sequencer.
//   state_t      - sequencer FSM states
//   KEY_*        - keypad codes with a fixed meaning (0-7 select an item)
//   item_price() - per-item price, in 5-cent units
//   coin_units() - credit value of a coin key, 0 for any other key
package vend_pkg;

    localparam int unsigned KEY_W    = 4;
    localparam int unsigned CREDIT_W = 8;
    localparam int unsigned ITEM_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SELECTED,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    localparam logic [KEY_W-1:0] KEY_COIN1  = 4'h8;
    localparam logic [KEY_W-1:0] KEY_COIN2  = 4'h9;
    localparam logic [KEY_W-1:0] KEY_COIN5  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_CANCEL = 4'hB;

    function automatic logic [CREDIT_W-1:0] item_price(input logic [ITEM_W-1:0] sel);
        case (sel)
            3'd0:    return 8'd3;
            3'd1:    return 8'd4;
            3'd2:    return 8'd5;
            3'd3:    return 8'd6;
            3'd4:    return 8'd7;
            3'd5:    return 8'd8;
            3'd6:    return 8'd10;
            default: return 8'd12;
        endcase
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_units(input logic [KEY_W-1:0] key);
        case (key)
            KEY_COIN1: return 8'd1;
            KEY_COIN2: return 8'd2;
            KEY_COIN5: return 8'd5;
            default:   return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_controller_debounce.sv
// key_debounce: turns the raw keypad scanner output into one accept strobe per press.
//   clk, reset  - clock, synchronous active-high reset
//   key_value   - decoded key code
//   key_valid   - high while a key is held
//   key_accept  - 1-cycle strobe, DEBOUNCE_CYCLES cycles after a stable press starts
//   key_code    - key code captured with the strobe
module key_debounce
    import vend_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [KEY_W-1:0] key_value,
    input  logic             key_valid,
    output logic             key_accept,
    output logic [KEY_W-1:0] key_code
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0]    r_hold_cnt;
    logic [CW-1:0]    r_rel_cnt;
    logic [KEY_W-1:0] r_last;
    logic             r_prev_valid;
    logic             r_armed;
    logic             r_accept;
    logic [KEY_W-1:0] r_code;

    logic             w_stable;
    logic [CW-1:0]    w_hold_next;
    logic [CW-1:0]    w_rel_next;

    // The current cycle counts as the first stable one, so a value change restarts at 1.
    assign w_stable    = key_valid && r_prev_valid && (key_value == r_last);
    assign w_hold_next = !w_stable ? CW'(1) :
                         (r_hold_cnt == CW'(DEBOUNCE_CYCLES)) ? r_hold_cnt : r_hold_cnt + CW'(1);
    assign w_rel_next  = (r_rel_cnt == CW'(DEBOUNCE_CYCLES)) ? r_rel_cnt : r_rel_cnt + CW'(1);

    // Hold/release counters; r_armed blocks a second accept until a full release.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_cnt   <= '0;
            r_rel_cnt    <= '0;
            r_last       <= '0;
            r_prev_valid <= 1'b0;
            r_armed      <= 1'b1;
            r_accept     <= 1'b0;
            r_code       <= '0;
        end else begin
            r_accept     <= 1'b0;
            r_prev_valid <= key_valid;
            r_last       <= key_value;
            if (key_valid) begin
                r_hold_cnt <= w_hold_next;
                r_rel_cnt  <= '0;
                if (r_armed && (w_hold_next == CW'(DEBOUNCE_CYCLES))) begin
                    r_accept <= 1'b1;
                    r_code   <= key_value;
                    r_armed  <= 1'b0;
                end
            end else begin
                r_hold_cnt <= '0;
                r_rel_cnt  <= w_rel_next;
                if (w_rel_next == CW'(DEBOUNCE_CYCLES)) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign key_accept = r_accept;
    assign key_code   = r_code;

endmodule

// File: rtl/vend_controller.sv
// vend_controller: vending-machine sequencer behind the keypad scanner.
//   clk, reset   - clock, synchronous active-high reset
//   key_value    - decoded key code (0-7 item, 8/9/A coin 1/2/5, B cancel)
//   key_valid    - high while a key is held
//   dispense     - dispense strobe, DISPENSE_CYCLES long; item valid meanwhile
//   item         - item being dispensed
//   change_pulse - one pulse per 5-cent unit returned
//   credit       - current credit in 5-cent units
//   busy         - high while dispensing or returning change
//   coin_reject  - pulse when a coin would exceed MAX_CREDIT
//   soldout      - pulse when the selected item has no stock
// Optional feature macro VEND_STOCK_EN: per-item stock counters and the soldout pulse;
// without it stock is unlimited and soldout is 0.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned         DEBOUNCE_CYCLES = 16,
    parameter int unsigned         DISPENSE_CYCLES = 8,
    parameter logic [CREDIT_W-1:0] MAX_CREDIT      = 8'd40
`ifdef VEND_STOCK_EN
    ,
    parameter logic [3:0]          STOCK_INIT      = 4'd5
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_W-1:0]    key_value,
    input  logic                key_valid,
    output logic                dispense,
    output logic [ITEM_W-1:0]   item,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                soldout
);

    localparam int unsigned DW = $clog2(DISPENSE_CYCLES + 1);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [ITEM_W-1:0]   r_sel;
    logic [DW-1:0]       r_disp_cnt;
    logic                r_dispense;
    logic [ITEM_W-1:0]   r_item;
    logic                r_change;
    logic                r_busy;
    logic                r_reject;

    logic                w_key_accept;
    logic [KEY_W-1:0]    w_key_code;
    logic                w_is_item;
    logic                w_is_coin;
    logic                w_is_cancel;
    logic [CREDIT_W-1:0] w_sum;
    logic                w_coin_ok;
    logic [CREDIT_W-1:0] w_new_price;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_in_stock;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_value (key_value),
        .key_valid (key_valid),
        .key_accept(w_key_accept),
        .key_code  (w_key_code)
    );

    // Key decode and credit arithmetic (max 40+5, no 8-bit overflow).
    assign w_is_item   = w_key_accept && !w_key_code[3];
    assign w_is_coin   = w_key_accept && (coin_units(w_key_code) != 8'd0);
    assign w_is_cancel = w_key_accept && (w_key_code == KEY_CANCEL);
    assign w_sum       = r_credit + coin_units(w_key_code);
    assign w_coin_ok   = (w_sum <= MAX_CREDIT);
    assign w_new_price = item_price(w_key_code[ITEM_W-1:0]);
    assign w_sel_price = item_price(r_sel);

`ifdef VEND_STOCK_EN
    logic [3:0] r_stock [8];
    logic       r_soldout;
    assign w_in_stock = (r_stock[w_key_code[ITEM_W-1:0]] != 4'd0);
    assign soldout    = r_soldout;
`else
    assign w_in_stock = 1'b1;
    assign soldout    = 1'b0;
`endif

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_credit   <= '0;
            r_sel      <= '0;
            r_disp_cnt <= '0;
            r_dispense <= 1'b0;
            r_item     <= '0;
            r_change   <= 1'b0;
            r_busy     <= 1'b0;
            r_reject   <= 1'b0;
`ifdef VEND_STOCK_EN
            r_soldout  <= 1'b0;
            for (int i = 0; i < 8; i++) r_stock[i] <= STOCK_INIT;
`endif
        end else begin
            r_reject  <= 1'b0;
`ifdef VEND_STOCK_EN
            r_soldout <= 1'b0;
`endif
            case (r_state)
                // Keys only act here, so accepts during DISPENSE/CHANGE are dropped.
                ST_IDLE, ST_SELECTED: begin
                    if (w_is_coin) begin
                        if (w_coin_ok) begin
                            r_credit <= w_sum;
                            if ((r_state == ST_SELECTED) && (w_sum >= w_sel_price)) begin
                                r_state <= ST_DISPENSE;
                                r_busy  <= 1'b1;
                            end
                        end else begin
                            r_reject <= 1'b1;
                        end
                    end else if (w_is_item) begin
                        if (w_in_stock) begin
                            r_sel <= w_key_code[ITEM_W-1:0];
                            if (r_credit >= w_new_price) begin
                                r_state <= ST_DISPENSE;
                                r_busy  <= 1'b1;
                            end else begin
                                r_state <= ST_SELECTED;
                            end
                        end else begin
`ifdef VEND_STOCK_EN
                            r_soldout <= 1'b1;
`endif
                        end
                    end else if (w_is_cancel) begin
                        if (r_credit != '0) begin
                            r_state <= ST_CHANGE;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                // First cycle charges the price and raises dispense; r_disp_cnt counts high cycles.
                ST_DISPENSE: begin
                    if (r_disp_cnt == '0) begin
                        r_credit   <= r_credit - w_sel_price;
                        r_dispense <= 1'b1;
                        r_item     <= r_sel;
                        r_disp_cnt <= DW'(1);
`ifdef VEND_STOCK_EN
                        r_stock[r_sel] <= r_stock[r_sel] - 4'd1;
`endif
                    end else if (r_disp_cnt == DW'(DISPENSE_CYCLES)) begin
                        r_dispense <= 1'b0;
                        r_disp_cnt <= '0;
                        if (r_credit != '0) begin
                            r_state <= ST_CHANGE;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_disp_cnt <= r_disp_cnt + DW'(1);
                    end
                end
                // One pulse every other cycle, credit follows each pulse.
                ST_CHANGE: begin
                    if (r_change) begin
                        r_change <= 1'b0;
                        r_credit <= r_credit - 8'd1;
                    end else if (r_credit == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_change <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign dispense     = r_dispense;
    assign item         = r_item;
    assign change_pulse = r_change;
    assign credit       = r_credit;
    assign busy         = r_busy;
    assign coin_reject  = r_reject;

endmodule
